// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: oversample tick, serial line, frame configuration,
// and the received word with its completion pulse and status flags.
interface uart_rx_cfg_if #(
    parameter int DATALEN = 8
);
    logic               btick;
    logic               rx;
    logic [1:0]         cfg_dlen;
    logic [1:0]         cfg_parity;
    logic               cfg_stop;
    logic [DATALEN-1:0] rx_data;
    logic               rx_done;
    logic               rx_busy;
    logic               parity_err;
    logic               frame_err;
    logic               break_det;

    // Baud generator / register-file side: drives tick, line and config.
    modport master (
        output btick, rx, cfg_dlen, cfg_parity, cfg_stop,
        input  rx_data, rx_done, rx_busy, parity_err, frame_err, break_det
    );

    // Receiver side.
    modport slave (
        input  btick, rx, cfg_dlen, cfg_parity, cfg_stop,
        output rx_data, rx_done, rx_busy, parity_err, frame_err, break_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable oversampling UART receiver: 5..DATALEN data bits,
// none/even/odd parity, 1 or 2 stop bits, 3-sample majority vote per bit,
// parity/framing error flags and break detection.
module uart_rx_cfg #(
    parameter int DATALEN     = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_cfg_if.slave bus
);
    localparam int TW = $clog2(OVS);
    localparam int CW = $clog2(DATALEN + 1);

    // Oversample positions: three votes around mid-bit, and the bit end.
    localparam logic [TW-1:0] T_S0  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [1:0]         smp_q, smp_d;
    logic               vote_q, vote_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]      dlen_q, dlen_d;
    logic [1:0]         par_q, par_d;
    logic               stop2_q, stop2_d;
    logic               stop_idx_q, stop_idx_d;
    logic [DATALEN-1:0] shift_q, shift_d;
    logic               perr_w_q, perr_w_d;
    logic               ferr_w_q, ferr_w_d;
    logic               pzero_q, pzero_d;
    logic               brk_w_q, brk_w_d;
    logic [DATALEN-1:0] rx_data_q, rx_data_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               brk_q, brk_d;
    logic               done_q, done_d;

    logic               rxs;
    logic               vote_now;
    logic               bit_end;
    logic               stop_vote;
    logic               par_en;
    logic               active;
    logic               brk_now;
    logic [CW-1:0]      dlen_sel;

    assign rxs       = sync_q[SYNC_STAGES-1];
    // Majority of the two stored samples and the live third sample.
    assign vote_now  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign active    = state_q inside {START, DATA, PARITY, STOP};
    assign bit_end   = bus.btick && (tcnt_q == T_END);
    assign stop_vote = bus.btick && (tcnt_q == T_S2);
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    // Break: all data zero, parity bit zero (if any), first stop bit zero.
    assign brk_now   = (shift_q == '0) && pzero_q && !vote_now;

    // Clamp the requested data length to what the datapath can hold.
    always_comb begin
        dlen_sel = CW'(DATALEN);
        if (5 + int'(bus.cfg_dlen) < DATALEN) begin
            dlen_sel = CW'(5 + int'(bus.cfg_dlen));
        end
    end

    // Input synchroniser; idles high like the line itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's pre-edge value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            smp_q      <= '0;
            vote_q     <= 1'b0;
            bit_cnt_q  <= '0;
            dlen_q     <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_w_q   <= 1'b0;
            ferr_w_q   <= 1'b0;
            pzero_q    <= 1'b1;
            brk_w_q    <= 1'b0;
            rx_data_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            smp_q      <= smp_d;
            vote_q     <= vote_d;
            bit_cnt_q  <= bit_cnt_d;
            dlen_q     <= dlen_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            perr_w_q   <= perr_w_d;
            ferr_w_q   <= ferr_w_d;
            pzero_q    <= pzero_d;
            brk_w_q    <= brk_w_d;
            rx_data_q  <= rx_data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: tick counting, vote sampling and frame sequencing.
    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave one unassigned (no latches).
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        smp_d      = smp_q;
        vote_d     = vote_q;
        bit_cnt_d  = bit_cnt_q;
        dlen_d     = dlen_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        perr_w_d   = perr_w_q;
        ferr_w_d   = ferr_w_q;
        pzero_d    = pzero_q;
        brk_w_d    = brk_w_q;
        rx_data_d  = rx_data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        done_d     = 1'b0;

        if (active && bus.btick) begin
            tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
            if (tcnt_q == T_S0) smp_d[0] = rxs;
            if (tcnt_q == T_S1) smp_d[1] = rxs;
            if (tcnt_q == T_S2) vote_d   = vote_now;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // Start detect: snapshot the frame format for this frame only.
                    state_d    = START;
                    tcnt_d     = '0;
                    dlen_d     = dlen_sel;
                    par_d      = bus.cfg_parity;
                    stop2_d    = bus.cfg_stop;
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    perr_w_d   = 1'b0;
                    ferr_w_d   = 1'b0;
                    pzero_d    = 1'b1;
                    brk_w_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = vote_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    for (int i = 0; i < DATALEN; i++) begin
                        if (bit_cnt_q == CW'(i)) shift_d[i] = vote_q;
                    end
                    if (bit_cnt_q == dlen_q - CW'(1)) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    // Received bit must equal XOR(data) for even, its inverse for odd.
                    perr_w_d = vote_q ^ (^shift_q) ^ (par_q == 2'b10);
                    pzero_d  = ~vote_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (stop_vote) begin
                    ferr_w_d = ferr_w_q | ~vote_now;
                    if (!stop_idx_q) brk_w_d = brk_now;
                    if (stop_idx_q == stop2_q) begin
                        // Last stop bit voted: publish now, do not wait for bit end.
                        done_d    = 1'b1;
                        rx_data_d = shift_q;
                        perr_d    = perr_w_q;
                        ferr_d    = ferr_w_q | ~vote_now;
                        brk_d     = stop_idx_q ? brk_w_q : brk_now;
                        state_d   = brk_d ? BRK : IDLE;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            BRK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_done    = done_q;
    assign bus.rx_busy    = active;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: the stimulus process pushes the expected
// frame result, the monitor pops and compares on every rx_done pulse.
module tb_uart_rx_cfg;
    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    uart_rx_cfg_if #(.DATALEN(8)) u_if ();

    uart_rx_cfg #(.DATALEN(8), .OVS(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample tick: one clk high every TICK_CLKS clks.
    initial begin
        int tc;
        tc = 0;
        u_if.btick = 1'b0;
        forever begin
            @(negedge clk);
            tc = (tc + 1) % TICK_CLKS;
            u_if.btick = (tc == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every rx_done against the oldest expected frame.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.rx_done === 1'b1) begin
                check("rx_done_was_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rx_data", 32'(u_if.rx_data), 32'(e.data));
                    check("parity_err", 32'(u_if.parity_err), 32'(e.perr));
                    check("frame_err", 32'(u_if.frame_err), 32'(e.ferr));
                    check("break_det", 32'(u_if.break_det), 32'(e.brk));
                    check("busy_before_done", 32'(prev_busy), 32'd1);
                    check("busy_at_done", 32'(u_if.rx_busy), 32'd0);
                end
            end
            prev_busy = u_if.rx_busy;
        end
    end

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        e.brk  = bk;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic v);
        u_if.rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // par: 0 none, 1 even, 2 odd. glitch_bit flips one tick of that data bit
    // around mid-bit; chg_bit rewrites cfg_dlen when that data bit starts.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input int nstop, input logic par_flip,
                              input logic stop2_zero, input int glitch_bit,
                              input int chg_bit);
        logic p;
        p = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            p = p ^ d[i];
            if (i == chg_bit) u_if.cfg_dlen = 2'd0;
            if (i == glitch_bit) begin
                u_if.rx = d[i];
                repeat (30) @(negedge clk);
                u_if.rx = ~d[i];
                repeat (TICK_CLKS) @(negedge clk);
                u_if.rx = d[i];
                repeat (BIT_CLKS - 30 - TICK_CLKS) @(negedge clk);
            end else begin
                send_bit(d[i]);
            end
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            if (par_flip) p = ~p;
            send_bit(p);
        end
        send_bit(1'b1);
        if (nstop == 2) send_bit(!stop2_zero);
    endtask

    task automatic set_cfg(input logic [1:0] dl, input logic [1:0] pa, input logic st);
        u_if.cfg_dlen   = dl;
        u_if.cfg_parity = pa;
        u_if.cfg_stop   = st;
    endtask

    // Watchdog: the sequence below is fixed-length, this only guards against a stuck run.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        u_if.rx  = 1'b1;
        set_cfg(2'd3, 2'd0, 1'b0);
        repeat (3) @(negedge clk);

        check("reset_rx_data", 32'(u_if.rx_data), 32'd0);
        check("reset_rx_done", 32'(u_if.rx_done), 32'd0);
        check("reset_rx_busy", 32'(u_if.rx_busy), 32'd0);
        check("reset_flags", {29'd0, u_if.parity_err, u_if.frame_err, u_if.break_det}, 32'd0);
        rst = 1'b0;
        idle_bits(2);

        // 8N1 0xA5, clean.
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 0, 1, 1'b0, 1'b0, -1, -1);
        idle_bits(2);

        // 7E1 0x41: correct even parity bit is 0, sent as 1.
        set_cfg(2'd2, 2'd1, 1'b0);
        push(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1, 1, 1'b1, 1'b0, -1, -1);
        idle_bits(2);

        // 5O2 0x15: correct odd parity (0), second stop bit driven 0.
        set_cfg(2'd0, 2'd2, 1'b1);
        push(8'h15, 1'b0, 1'b1, 1'b0);
        send_frame(8'h15, 5, 2, 2, 1'b0, 1'b1, -1, -1);
        idle_bits(2);

        // Glitch: rx low for 4 bticks is a false start.
        set_cfg(2'd3, 2'd0, 1'b0);
        u_if.rx = 1'b0;
        repeat (4 * TICK_CLKS) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_in_start", 32'(u_if.rx_busy), 32'd1);
        repeat (80) @(negedge clk);
        check("glitch_busy_after_start", 32'(u_if.rx_busy), 32'd0);
        check("flags_hold_data", 32'(u_if.rx_data), 32'h15);
        check("flags_hold_ferr", 32'(u_if.frame_err), 32'd1);
        idle_bits(1);

        // Reset during data bit 4 of 8N1 0x99: aborted, no rx_done.
        d = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        u_if.rx = d[4];
        repeat (32) @(negedge clk);
        check("busy_before_reset", 32'(u_if.rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_rx_data", 32'(u_if.rx_data), 32'd0);
        check("midreset_rx_busy", 32'(u_if.rx_busy), 32'd0);
        check("midreset_rx_done", 32'(u_if.rx_done), 32'd0);
        check("midreset_frame_err", 32'(u_if.frame_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        u_if.rx = 1'b1;
        idle_bits(11);

        // 8N1 0xC3 after the reset.
        push(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 0, 1, 1'b0, 1'b0, -1, -1);
        idle_bits(2);

        // 8N1 0x3C with one bad sample near mid of data bit 3.
        push(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 0, 1, 1'b0, 1'b0, 3, -1);
        idle_bits(2);

        // Break: 3 frame times low, then 0x5A.
        push(8'h00, 1'b0, 1'b1, 1'b1);
        u_if.rx = 1'b0;
        repeat (30 * BIT_CLKS) @(negedge clk);
        idle_bits(2);
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 0, 1, 1'b0, 1'b0, -1, -1);
        idle_bits(2);

        // cfg_dlen dropped to 5 bits during data bit 2: frame stays 8 bits.
        push(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 8, 0, 1, 1'b0, 1'b0, -1, 2);
        idle_bits(2);

        // 8E2 0xFF, correct parity (0), both stop bits good.
        set_cfg(2'd3, 2'd1, 1'b1);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 8, 1, 2, 1'b0, 1'b0, -1, -1);
        idle_bits(3);

        check("all_frames_seen", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
